// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Tuse/Tnew hazard unit for the pipelined MIPS core. It sits beside the
//   D stage and is fed by the decoded A/T fields of the D instruction.
//
//   The unit keeps a shift scoreboard of (dest reg, remaining Tnew) for
//   every stage after D: entry 0 = E, entry 1 = M, entry 2 = W, and so on.
//   From the scoreboard it derives three things:
//     - stall       : the D instruction must wait
//     - fwd_sel     : per-source D-stage forward selects
//     - mdu_busy    : the multiply/divide unit is still counting down
//
//   Optional feature macro: HAZARD_MDU_EN
//     defined   -> MDU busy counter, mdu_busy and the MDU hazard are built
//     undefined -> no counter; mdu_busy is tied to 0 and the MDU inputs are
//                  ignored, so stall covers data hazards only
//
//   Ports
//     clk         in   1        rising-edge clock
//     reset       in   1        asynchronous, active-high reset
//     d_a         in   NSRC*5   source reg numbers, src i at [5i+4:5i]
//     d_tuse      in   NSRC*TW  Tuse per source, same packing
//     d_a3        in   5        destination reg of D instruction (0 = none)
//     d_tnew      in   TW       Tnew of D instruction, counted from D
//     d_mdureq    in   1        D instruction uses the MDU
//     d_mdustart  in   1        D instruction is mult/multu/div/divu
//     d_isdiv     in   1        with d_mdustart: 1 = div/divu, 0 = mult/multu
//     stall       out  1        hold F/D and inject a bubble into E
//     fwd_sel     out  NSRC*3   per source: 0 = RF, k+1 = forward from stage k
//     mdu_busy    out  1        MDU counter nonzero
module hazard_scoreboard #(
  parameter int NSRC     = 2,
  parameter int DEPTH    = 3,
  parameter int TW       = 2,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NSRC*5-1:0]    d_a,
  input  logic [NSRC*TW-1:0]   d_tuse,
  input  logic [4:0]           d_a3,
  input  logic [TW-1:0]        d_tnew,
  input  logic                 d_mdureq,
  input  logic                 d_mdustart,
  input  logic                 d_isdiv,
  output logic                 stall,
  output logic [NSRC*3-1:0]    fwd_sel,
  output logic                 mdu_busy
);

  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] x);
    return (x == '0) ? '0 : x - TW'(1);
  endfunction

  logic [4:0]      r_a3   [DEPTH];
  logic [TW-1:0]   r_tnew [DEPTH];

  logic [NSRC-1:0] w_data_haz;
  logic            w_mdu_haz;
  logic [4:0]      w_src;
  logic            w_hit;
  logic [TW-1:0]   w_tn;
  logic [2:0]      w_k;

  // Scoreboard shift: happens on every edge; a stalled edge feeds a bubble
  // into E instead of the held D instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_a3[k]   <= '0;
        r_tnew[k] <= '0;
      end
    end else begin
      if (stall) begin
        r_a3[0]   <= '0;
        r_tnew[0] <= '0;
      end else begin
        r_a3[0]   <= d_a3;
        r_tnew[0] <= sat_dec(d_tnew);
      end
      for (int k = 1; k < DEPTH; k++) begin
        r_a3[k]   <= r_a3[k-1];
        r_tnew[k] <= sat_dec(r_tnew[k-1]);
      end
    end
  end

  // Match/hazard/forward: the scan runs from oldest to youngest so the
  // youngest matching entry is the one left standing. $0 never matches,
  // which also makes entries with a3=0 (bubbles) invisible.
  always_comb begin
    w_data_haz = '0;
    fwd_sel    = '0;
    w_src      = '0;
    w_hit      = 1'b0;
    w_tn       = '0;
    w_k        = '0;
    for (int i = 0; i < NSRC; i++) begin
      w_src = d_a[5*i +: 5];
      w_hit = 1'b0;
      w_tn  = '0;
      w_k   = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if ((w_src != 5'd0) && (w_src == r_a3[k])) begin
          w_hit = 1'b1;
          w_tn  = r_tnew[k];
          w_k   = 3'(k + 1);
        end
      end
      w_data_haz[i]     = w_hit && (w_tn > d_tuse[TW*i +: TW]);
      fwd_sel[3*i +: 3] = (w_hit && (w_tn == '0)) ? w_k : 3'd0;
    end
  end

`ifdef HAZARD_MDU_EN
  localparam int MAXC = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  logic [CW-1:0] r_mdu_cnt;

  // MDU busy counter: loaded only by an issuing mult/div; a held start
  // cannot reload it because a busy MDU already forces stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mdu_cnt <= '0;
    end else if (!stall && d_mdustart) begin
      r_mdu_cnt <= d_isdiv ? CW'(DIV_CYC) : CW'(MULT_CYC);
    end else if (r_mdu_cnt != '0) begin
      r_mdu_cnt <= r_mdu_cnt - CW'(1);
    end
  end

  assign mdu_busy  = (r_mdu_cnt != '0);
  assign w_mdu_haz = d_mdureq && mdu_busy;
`else
  logic w_unused_mdu;
  assign w_unused_mdu = ^{d_mdureq, d_mdustart, d_isdiv};
  assign mdu_busy     = 1'b0;
  assign w_mdu_haz    = 1'b0;
`endif

  assign stall = (|w_data_haz) | w_mdu_haz;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
  localparam int NSRC     = 2;
  localparam int DEPTH    = 3;
  localparam int TW       = 2;
  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;
`ifdef HAZARD_MDU_EN
  localparam bit MDU_ON = 1'b1;
`else
  localparam bit MDU_ON = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NSRC*5-1:0]    d_a;
  logic [NSRC*TW-1:0]   d_tuse;
  logic [4:0]           d_a3;
  logic [TW-1:0]        d_tnew;
  logic                 d_mdureq;
  logic                 d_mdustart;
  logic                 d_isdiv;
  logic                 stall;
  logic [NSRC*3-1:0]    fwd_sel;
  logic                 mdu_busy;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .NSRC(NSRC), .DEPTH(DEPTH), .TW(TW), .MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)
  ) dut (
    .clk(clk), .reset(reset), .d_a(d_a), .d_tuse(d_tuse), .d_a3(d_a3),
    .d_tnew(d_tnew), .d_mdureq(d_mdureq), .d_mdustart(d_mdustart),
    .d_isdiv(d_isdiv), .stall(stall), .fwd_sel(fwd_sel), .mdu_busy(mdu_busy)
  );

  typedef struct {
    string      tag;
    logic       st;
    logic [5:0] fs;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic drive(input logic [4:0] a0, input logic [4:0] a1,
                       input logic [1:0] u0, input logic [1:0] u1,
                       input logic [4:0] a3, input logic [1:0] tn,
                       input logic req, input logic start, input logic isdiv);
    d_a        = {a1, a0};
    d_tuse     = {u1, u0};
    d_a3       = a3;
    d_tnew     = tn;
    d_mdureq   = req;
    d_mdustart = start;
    d_isdiv    = isdiv;
  endtask

  task automatic expect_out(input string tag, input logic st,
                            input logic [2:0] f1, input logic [2:0] f0,
                            input logic busy);
    exp_t e;
    e.tag  = tag;
    e.st   = st;
    e.fs   = {f1, f0};
    e.busy = busy;
    exp_q.push_back(e);
  endtask

  // Outputs are combinational; they are sampled 1 ns after inputs change,
  // well inside the low clock phase.
  task automatic settle_check();
    exp_t e;
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks += 3;
      assert (stall === e.st) else begin
        failures++;
        $error("FAIL %s stall observed=%0b expected=%0b", e.tag, stall, e.st);
      end
      assert (fwd_sel === e.fs) else begin
        failures++;
        $error("FAIL %s fwd_sel observed=%0h expected=%0h", e.tag, fwd_sel, e.fs);
      end
      assert (mdu_busy === e.busy) else begin
        failures++;
        $error("FAIL %s mdu_busy observed=%0b expected=%0b", e.tag, mdu_busy, e.busy);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    expect_out("reset_idle", 0, 0, 0, 0); settle_check();
    reset = 1'b0;

    // lw $3 (tnew 3) then addu $4,$3,$2 (tuse 1): one stall cycle
    drive(1, 0, 1, 1, 3, 3, 0, 0, 0);
    expect_out("lw_issue", 0, 0, 0, 0); settle_check();
    @(negedge clk);
    drive(3, 2, 1, 1, 4, 2, 0, 0, 0);
    expect_out("lw_use_stall", 1, 0, 0, 0); settle_check();
    @(negedge clk);
    expect_out("lw_use_release", 0, 0, 0, 0); settle_check();
    @(negedge clk);

    // addu $5 (tnew 2) then beq $5,$0 (tuse 0): stall, then forward from M
    drive(1, 1, 1, 1, 5, 2, 0, 0, 0);
    expect_out("addu5_issue", 0, 0, 0, 0); settle_check();
    @(negedge clk);
    drive(5, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("beq_stall", 1, 0, 0, 0); settle_check();
    @(negedge clk);
    expect_out("beq_fwd_m", 0, 0, 2, 0); settle_check();
    @(negedge clk);

    // writes to $0 never create a hazard or a forward
    drive(1, 2, 1, 1, 0, 2, 0, 0, 0);
    expect_out("addu0_issue", 0, 0, 0, 0); settle_check();
    @(negedge clk);
    drive(0, 0, 1, 1, 6, 3, 0, 0, 0);
    expect_out("read_r0", 0, 0, 0, 0); settle_check();
    @(negedge clk);

    // ori $7 in M, addu $7 in E, D reads $7: the E entry wins
    drive(0, 0, 1, 1, 7, 2, 0, 0, 0);
    expect_out("ori7_issue", 0, 0, 0, 0); settle_check();
    @(negedge clk);
    drive(1, 1, 1, 1, 7, 2, 0, 0, 0);
    expect_out("addu7_issue", 0, 0, 0, 0); settle_check();
    @(negedge clk);
    drive(7, 6, 0, 1, 0, 0, 0, 0, 0);
    expect_out("young_tuse0", 1, 3, 0, 0); settle_check();
    drive(7, 6, 1, 1, 0, 0, 0, 0, 0);
    expect_out("young_tuse1", 0, 3, 0, 0); settle_check();
    @(negedge clk);
    drive(7, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("r7_fwd_m", 0, 0, 2, 0); settle_check();
    @(negedge clk);

    // d_tnew=0 is ready at once: forward from E
    drive(0, 0, 0, 0, 8, 0, 0, 0, 0);
    expect_out("tnew0_issue", 0, 0, 0, 0); settle_check();
    @(negedge clk);
    drive(8, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("tnew0_fwd_e", 0, 0, 1, 0); settle_check();
    @(negedge clk);

    // mult then mflo
    drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
    expect_out("mult_issue", 0, 0, 0, 0); settle_check();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int c = 0; c < MULT_CYC; c++) begin
      expect_out($sformatf("mult_wait%0d", c), MDU_ON, 0, 0, MDU_ON); settle_check();
      @(negedge clk);
    end
    expect_out("mult_done", 0, 0, 0, 0); settle_check();
    @(negedge clk);

    // div then mflo
    drive(0, 0, 0, 0, 0, 0, 1, 1, 1);
    expect_out("div_issue", 0, 0, 0, 0); settle_check();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int c = 0; c < DIV_CYC; c++) begin
      expect_out($sformatf("div_wait%0d", c), MDU_ON, 0, 0, MDU_ON); settle_check();
      @(negedge clk);
    end
    expect_out("div_done", 0, 0, 0, 0); settle_check();
    @(negedge clk);

    // fill scoreboard and MDU, then reset asynchronously mid-cycle
    drive(0, 0, 0, 0, 9, 3, 1, 1, 0);
    expect_out("fill9", 0, 0, 0, 0); settle_check();
    @(negedge clk);
    drive(0, 0, 0, 0, 10, 3, 0, 0, 0);
    expect_out("fill10", 0, 0, 0, MDU_ON); settle_check();
    @(negedge clk);
    drive(0, 0, 0, 0, 11, 3, 0, 0, 0);
    expect_out("fill11", 0, 0, 0, MDU_ON); settle_check();
    @(negedge clk);
    drive(11, 9, 0, 0, 0, 0, 1, 0, 0);
    expect_out("full_pre_reset", 1, 3, 0, MDU_ON); settle_check();
    reset = 1'b1;
    expect_out("async_reset", 0, 0, 0, 0); settle_check();
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("post_reset_idle", 0, 0, 0, 0); settle_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
